// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: CPU instruction/data ports and shared memory bus seen by the arbiter
interface cpu_mem_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_req;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        proto_err;

    modport slave (
        input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               mem_ready, mem_rvalid, mem_rdata,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
               mem_req, mem_we, mem_addr, mem_mask, mem_wdata, proto_err
    );

    modport master (
        output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               mem_ready, mem_rvalid, mem_rdata,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
               mem_req, mem_we, mem_addr, mem_mask, mem_wdata, proto_err
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serves CPU imem/dmem ports from one memory bus, one transaction at a time
module cpu_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    cpu_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q;
    logic [3:0]  starve_q;
    logic        owner_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_mask_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] imem_rdata_q;
    logic [31:0] dmem_rdata_q;
    logic        imem_resp_q;
    logic        dmem_resp_q;
    logic        proto_err_q;

    logic        imem_pend;
    logic        dmem_pend;
    logic        dmem_we;
    logic        grant_dmem_d;
    logic [3:0]  starve_d;
    logic [31:0] addr_d;
    logic [3:0]  mask_d;

    // Arbitration: dmem wins unless imem has been passed over STARVE_LIMIT times in a row
    always_comb begin
        imem_pend    = bus.imem_rmask != 4'b0;
        dmem_pend    = (bus.dmem_rmask | bus.dmem_wmask) != 4'b0;
        dmem_we      = bus.dmem_wmask != 4'b0;
        grant_dmem_d = dmem_pend && !(imem_pend && starve_q == LIMIT);
        addr_d       = (grant_dmem_d ? bus.dmem_addr : bus.imem_addr) & 32'hFFFF_FFFC;
        mask_d       = grant_dmem_d ? (dmem_we ? bus.dmem_wmask : bus.dmem_rmask) : bus.imem_rmask;
        starve_d     = !grant_dmem_d ? 4'd0 :
                       (imem_pend && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
    end

    // Transaction FSM with all bus and CPU outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            owner_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_mask_q   <= '0;
            mem_wdata_q  <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            imem_resp_q  <= 1'b0;
            dmem_resp_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            if (bus.mem_rvalid && state_q != WAIT)
                proto_err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (imem_pend || dmem_pend) begin
                        owner_q     <= grant_dmem_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= grant_dmem_d && dmem_we;
                        mem_addr_q  <= addr_d;
                        mem_mask_q  <= mask_d;
                        mem_wdata_q <= grant_dmem_d ? bus.dmem_wdata : 32'd0;
                        starve_q    <= starve_d;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (!mem_we_q && owner_q)
                            dmem_rdata_q <= bus.mem_rdata;
                        if (!owner_q)
                            imem_rdata_q <= bus.mem_rdata;
                        imem_resp_q <= !owner_q;
                        dmem_resp_q <= owner_q;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    imem_resp_q <= 1'b0;
                    dmem_resp_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_mask   = mem_mask_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.imem_rdata = imem_rdata_q;
    assign bus.dmem_rdata = dmem_rdata_q;
    assign bus.imem_resp  = imem_resp_q;
    assign bus.dmem_resp  = dmem_resp_q;
    assign bus.proto_err  = proto_err_q;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed checks of fetch, load/store, starvation, backpressure and protocol errors
module tb_cpu_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;
    logic [31:0] imem_exp = '0;
    logic [31:0] dmem_exp = '0;

    cpu_mem_arbiter_if bus ();

    cpu_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "/mem_req"}, 32'(bus.mem_req), 0);
        check({tag, "/mem_we"}, 32'(bus.mem_we), 0);
        check({tag, "/mem_addr"}, bus.mem_addr, 0);
        check({tag, "/mem_mask"}, 32'(bus.mem_mask), 0);
        check({tag, "/mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "/imem_rdata"}, bus.imem_rdata, 0);
        check({tag, "/dmem_rdata"}, bus.dmem_rdata, 0);
        check({tag, "/resps"}, {30'd0, bus.imem_resp, bus.dmem_resp}, 0);
        check({tag, "/proto_err"}, 32'(bus.proto_err), 0);
    endtask

    // Runs one transaction starting in IDLE with the CPU request already driven.
    task automatic txn(input string tag, input logic exp_d, input logic exp_we,
                       input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                       input logic [31:0] exp_wdata, input logic [31:0] rdata,
                       input int stall, input logic drop);
        check({tag, "/idle"}, 32'(bus.mem_req), 0);
        bus.mem_ready = (stall == 0);
        tick();
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) bus.mem_ready = 1'b1;
            check({tag, "/req"}, 32'(bus.mem_req), 1);
            check({tag, "/addr"}, bus.mem_addr, exp_addr);
            check({tag, "/mask"}, 32'(bus.mem_mask), 32'(exp_mask));
            check({tag, "/we"}, 32'(bus.mem_we), 32'(exp_we));
            if (exp_we) check({tag, "/wdata"}, bus.mem_wdata, exp_wdata);
            tick();
        end
        check({tag, "/wait"}, 32'(bus.mem_req), 0);
        check({tag, "/early_resp"}, {30'd0, bus.imem_resp, bus.dmem_resp}, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        tick();
        bus.mem_rvalid = 1'b0;
        if (!exp_we) begin
            if (exp_d) dmem_exp = rdata;
            else imem_exp = rdata;
        end
        check({tag, "/imem_resp"}, 32'(bus.imem_resp), 32'(!exp_d));
        check({tag, "/dmem_resp"}, 32'(bus.dmem_resp), 32'(exp_d));
        check({tag, "/imem_rdata"}, bus.imem_rdata, imem_exp);
        check({tag, "/dmem_rdata"}, bus.dmem_rdata, dmem_exp);
        if (drop) begin
            if (exp_d) begin
                bus.dmem_rmask = '0;
                bus.dmem_wmask = '0;
            end else begin
                bus.imem_rmask = '0;
            end
        end
        tick();
        check({tag, "/resp_end"}, {30'd0, bus.imem_resp, bus.dmem_resp}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.imem_addr  = '0;
        bus.imem_rmask = '0;
        bus.dmem_addr  = '0;
        bus.dmem_rmask = '0;
        bus.dmem_wmask = '0;
        bus.dmem_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b1;
        tick();
        check_outputs_zero("post_reset");

        bus.imem_addr  = 32'h0000_1000;
        bus.imem_rmask = 4'hF;
        txn("fetch", 1'b0, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 32'h0000_0013, 0, 1'b1);

        bus.dmem_addr  = 32'h0000_3004;
        bus.dmem_rmask = 4'hF;
        txn("load", 1'b1, 1'b0, 32'h0000_3004, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);

        bus.dmem_addr  = 32'h0000_2002;
        bus.dmem_rmask = 4'h3;
        bus.dmem_wmask = 4'hC;
        bus.dmem_wdata = 32'hAABB_0000;
        txn("store", 1'b1, 1'b1, 32'h0000_2000, 4'hC, 32'hAABB_0000, 32'h5555_5555, 0, 1'b1);

        bus.imem_addr  = 32'h0000_1006;
        bus.imem_rmask = 4'hF;
        txn("stall", 1'b0, 1'b0, 32'h0000_1004, 4'hF, 32'h0, 32'h0040_0093, 5, 1'b1);

        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        check("spur/proto_err", 32'(bus.proto_err), 1);
        check("spur/imem_rdata", bus.imem_rdata, imem_exp);
        check("spur/dmem_rdata", bus.dmem_rdata, dmem_exp);
        check("spur/resps", {30'd0, bus.imem_resp, bus.dmem_resp}, 0);
        tick();
        check("spur/sticky", 32'(bus.proto_err), 1);
        check("spur/no_req", 32'(bus.mem_req), 0);

        bus.imem_addr  = 32'h0000_1000;
        bus.imem_rmask = 4'hF;
        bus.dmem_addr  = 32'h0000_3000;
        bus.dmem_rmask = 4'hF;
        bus.dmem_wmask = 4'h0;
        for (int n = 0; n < 10; n++) begin
            logic d;
            d = (n % 5) != 4;
            txn($sformatf("contend%0d", n), d, 1'b0, d ? 32'h0000_3000 : 32'h0000_1000,
                4'hF, 32'h0, 32'h0000_0100 + 32'(n), 0, 1'b0);
        end
        bus.imem_rmask = '0;
        bus.dmem_rmask = '0;
        tick();

        bus.dmem_addr  = 32'h0000_3008;
        bus.dmem_rmask = 4'hF;
        bus.mem_ready  = 1'b1;
        tick();
        check("rst_wait/req", 32'(bus.mem_req), 1);
        tick();
        check("rst_wait/wait", 32'(bus.mem_req), 0);
        #1;
        rst = 1'b0;
        bus.dmem_rmask = '0;
        #1;
        imem_exp = '0;
        dmem_exp = '0;
        check_outputs_zero("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0077;
        tick();
        bus.mem_rvalid = 1'b0;
        check("late/proto_err", 32'(bus.proto_err), 1);
        check("late/resps", {30'd0, bus.imem_resp, bus.dmem_resp}, 0);
        check("late/dmem_rdata", bus.dmem_rdata, dmem_exp);
        tick();
        check("late/sticky", 32'(bus.proto_err), 1);
        check("late/resps2", {30'd0, bus.imem_resp, bus.dmem_resp}, 0);
        check("late/no_req", 32'(bus.mem_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shared-memory arbiter that sits directly below `cpu` and serves its `imem_*` and `dmem_*` ports from a single memory bus. It arbitrates between the two CPU ports and issues one bus transaction at a time. It returns read data and a one-cycle `*_resp` pulse to the port that issued the transaction. Data-port priority is bounded by a starvation counter, so instruction fetch always makes progress.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive dmem grants allowed while imem is pending before imem is forced to win; legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset; asserted when 0.
- `imem_addr`  in  32  fetch address from cpu.
- `imem_rmask`  in  4  fetch byte mask; nonzero = request present.
- `imem_rdata`  out  32  fetch data; valid when `imem_resp`=1.
- `imem_resp`  out  1  one-cycle fetch completion pulse.
- `dmem_addr`  in  32  data address.
- `dmem_rmask`  in  4  load byte mask.
- `dmem_wmask`  in  4  store byte mask; nonzero = store (wins over `dmem_rmask`).
- `dmem_wdata`  in  32  store data.
- `dmem_rdata`  out  32  load data; valid when `dmem_resp`=1.
- `dmem_resp`  out  1  one-cycle load/store completion pulse.
- `mem_req`  out  1  bus request valid.
- `mem_ready`  in  1  bus accepts request when `mem_req`&&`mem_ready`.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  bus address, `{addr[31:2],2'b00}`.
- `mem_mask`  out  4  byte mask of granted request.
- `mem_wdata`  out  32  write data.
- `mem_rvalid`  in  1  completion strobe for reads and writes (exactly one per accepted request).
- `mem_rdata`  in  32  read data; valid with `mem_rvalid`.
- `proto_err`  out  1  sticky: `mem_rvalid` received outside WAIT.

## Operation
- Port request: imem pending iff `imem_rmask!=0`; dmem pending iff `(dmem_rmask|dmem_wmask)!=0`. CPU holds request fields stable until its `*_resp`; any request seen in IDLE is a new request.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any pending, grant and latch addr/mask/wdata/we/owner; go REQ. Otherwise stay.
- Arbitration: dmem wins unless imem pending and `starve_cnt==STARVE_LIMIT`. Only one pending: it wins.
- `starve_cnt` (4 bits): +1 on a dmem grant while imem pending (saturates at STARVE_LIMIT); cleared on any imem grant; unchanged otherwise.
- REQ: `mem_req`=1 with latched fields; on `mem_ready` go WAIT.
- WAIT: on `mem_rvalid`, capture `mem_rdata` into owner's rdata register (reads only; writes leave `dmem_rdata` unchanged); go RESP.
- RESP: owner's `*_resp`=1 for exactly this cycle; no arbitration; go IDLE.
- `mem_rvalid` in IDLE/REQ/RESP: ignored for data, sets `proto_err` (cleared only by reset).
- Bus fields `mem_we/mem_addr/mem_mask/mem_wdata` are held from latched registers; don't-care but stable while `mem_req`=0.

## Timing
- Reset (rst=0, async): state IDLE; `mem_req`, `mem_we`, `imem_resp`, `dmem_resp`, `proto_err`=0; `mem_addr`, `mem_mask`, `mem_wdata`, `imem_rdata`, `dmem_rdata`=0; `starve_cnt`=0. Reset mid-transaction abandons it; a late `mem_rvalid` after release sets `proto_err`.
- All outputs are registered; no combinational path from any input to any output.
- Minimum latency: request visible at cycle T in IDLE → `mem_req` at T+1. With `mem_ready` at T+1 and `mem_rvalid` at T+2, `*_resp` occurs at T+3 and IDLE at T+4.
- `mem_ready` stalls: `mem_req` and its fields are held unchanged until accepted.
- Back-to-back: the next grant is decided in the IDLE cycle following RESP, so bus throughput is 1 transaction per ≥4 cycles.
- Simultaneous requests in IDLE follow the arbitration rule above. The loser stays pending, unaffected.
- `mem_rvalid` in the same cycle as `mem_ready`'s acceptance is illegal; it is flagged via `proto_err` because the FSM is still in REQ.

## Test plan
- Single fetch: imem_addr=0x1000, rmask=0xF; ready=1 immediately, rvalid 1 cycle later, rdata=0x00000013 → mem_req 1 cycle after request, imem_resp pulse at T+3 with imem_rdata=0x00000013, mem_we=0.
- Store: dmem_addr=0x2002, wmask=0xC, wdata=0xAABB0000 → mem_we=1, mem_addr=0x2000, mem_mask=0xC, mem_wdata=0xAABB0000; dmem_resp pulse; dmem_rdata unchanged.
- Contention and starvation (STARVE_LIMIT=4): both ports continuously pending → grant order dmem×4, imem, dmem×4, imem…; starve_cnt cleared after each imem grant.
- Backpressure: mem_ready low for 5 cycles → mem_req and fields held constant for 5 cycles, accepted on 6th; resp follows normally.
- Reset mid-WAIT: deassert-to-assert rst while in WAIT → outputs zero immediately; after release, stray mem_rvalid → proto_err=1 and stays 1, no resp pulse.
- Spurious rvalid in IDLE: no pending requests, mem_rvalid=1 → proto_err=1; imem_rdata/dmem_rdata unchanged.
